// File: rtl/byte_feeder_if.sv
// Word-stream input and byte-lane output bundle of the byte feeder.
// The slave modport is the feeder's view; master is the driving/observing side.
interface byte_feeder_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_last;
    logic [1:0]  last_bytes;
    logic        word_ready;
    logic        stall;
    logic [31:0] data_save;
    logic [2:0]  count_out;
    logic        count_enable;
    logic        busy;
    logic        msg_done;
    logic [15:0] byte_total;
    logic        ascii_err;

    modport slave (
        input  word_in, word_valid, word_last, last_bytes, stall,
        output word_ready, data_save, count_out, count_enable,
               busy, msg_done, byte_total, ascii_err
    );

    modport master (
        output word_in, word_valid, word_last, last_bytes, stall,
        input  word_ready, data_save, count_out, count_enable,
               busy, msg_done, byte_total, ascii_err
    );
endinterface

// File: rtl/byte_feeder.sv
// Buffers 32-bit message words in a small FIFO and presents them one byte lane
// per cycle to the frequency-count table, with stall, ASCII check and end-of-message.
module byte_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    byte_feeder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
        logic [2:0]  nbytes;
    } entry_t;

    entry_t      fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] fill;
    logic        full, empty, push, pop;
    entry_t      push_entry, head;

    state_t      state_q, state_d;
    logic [31:0] data_save_q, data_save_d;
    logic [2:0]  count_out_q, count_out_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        last_q, last_d;
    logic        msg_done_q, msg_done_d;
    logic        ascii_err_q, ascii_err_d;
    logic        msg_open_q, msg_open_d;
    logic [15:0] byte_total_q, byte_total_d;
    logic [7:0]  sel_byte;
    logic        advance, count_enable;

    always_comb begin
        fill              = wr_ptr_q - rd_ptr_q;
        full              = (fill == (AW+1)'(FIFO_DEPTH));
        empty             = (wr_ptr_q == rd_ptr_q);
        push              = bus.word_valid && !full;
        push_entry.word   = bus.word_in;
        push_entry.last   = bus.word_last;
        push_entry.nbytes = (bus.word_last && bus.last_bytes != 2'd0) ? {1'b0, bus.last_bytes} : 3'd4;
        head              = fifo_mem[rd_ptr_q[AW-1:0]];
        wr_ptr_d          = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d          = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    always_comb begin
        case (count_out_q)
            3'd1:    sel_byte = data_save_q[7:0];
            3'd2:    sel_byte = data_save_q[15:8];
            3'd3:    sel_byte = data_save_q[23:16];
            3'd4:    sel_byte = data_save_q[31:24];
            default: sel_byte = 8'h00;
        endcase
        advance      = (state_q == EMIT) && !bus.stall;
        count_enable = advance && !sel_byte[7];
    end

    always_comb begin
        state_d      = state_q;
        data_save_d  = data_save_q;
        count_out_d  = count_out_q;
        nbytes_d     = nbytes_q;
        last_d       = last_q;
        msg_done_d   = 1'b0;
        ascii_err_d  = ascii_err_q;
        msg_open_d   = msg_open_q;
        byte_total_d = byte_total_q;
        pop          = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EMIT;
                    // msg_open distinguishes a FIFO underrun mid-message from a new message
                    if (!msg_open_q) begin
                        byte_total_d = 16'h0000;
                        ascii_err_d  = 1'b0;
                        msg_open_d   = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (advance) begin
                    if (sel_byte[7]) begin
                        ascii_err_d = 1'b1;
                    end else if (byte_total_q != 16'hFFFF) begin
                        byte_total_d = byte_total_q + 16'd1;
                    end
                    if (count_out_q < nbytes_q) begin
                        count_out_d = count_out_q + 3'd1;
                    end else if (last_q) begin
                        state_d     = DONE;
                        count_out_d = 3'd0;
                        msg_done_d  = 1'b1;
                        msg_open_d  = 1'b0;
                    end else if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        count_out_d = 3'd0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            data_save_d = head.word;
            last_d      = head.last;
            nbytes_d    = head.nbytes;
            count_out_d = 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= IDLE;
            data_save_q  <= 32'h0;
            count_out_q  <= 3'd0;
            nbytes_q     <= 3'd0;
            last_q       <= 1'b0;
            msg_done_q   <= 1'b0;
            ascii_err_q  <= 1'b0;
            msg_open_q   <= 1'b0;
            byte_total_q <= 16'h0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            data_save_q  <= data_save_d;
            count_out_q  <= count_out_d;
            nbytes_q     <= nbytes_d;
            last_q       <= last_d;
            msg_done_q   <= msg_done_d;
            ascii_err_q  <= ascii_err_d;
            msg_open_q   <= msg_open_d;
            byte_total_q <= byte_total_d;
        end
    end

    assign bus.word_ready   = !full;
    assign bus.data_save    = data_save_q;
    assign bus.count_out    = count_out_q;
    assign bus.count_enable = count_enable;
    assign bus.busy         = !empty || (state_q != IDLE);
    assign bus.msg_done     = msg_done_q;
    assign bus.byte_total   = byte_total_q;
    assign bus.ascii_err    = ascii_err_q;
endmodule

// File: tb/tb_byte_feeder.sv
// Self-checking bench for byte_feeder: a lane/byte scoreboard fed at each accepted
// word, a table of single-word messages, and cycle-exact corner-case sequences.
module tb_byte_feeder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    byte_feeder_if bif();

    byte_feeder #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct packed {
        logic [2:0] lane;
        logic [7:0] b;
    } sb_t;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  lb;
        int          exp_total;
        logic        exp_err;
    } vec_t;

    sb_t  exp_q[$];
    vec_t vecs[7];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt, first_en, last_en, done_cnt, done_total;
    logic done_err;
    logic hs_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [2:0] lane);
        logic [7:0] r;
        case (lane)
            3'd1:    r = w[7:0];
            3'd2:    r = w[15:8];
            3'd3:    r = w[23:16];
            3'd4:    r = w[31:24];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic sb_push(input logic [31:0] w, input logic last, input logic [1:0] lb);
        int nb;
        sb_t e;
        nb = (last && lb != 2'd0) ? int'(lb) : 4;
        for (int l = 1; l <= nb; l++) begin
            e.lane = 3'(l);
            e.b    = lane_byte(w, 3'(l));
            if (!e.b[7]) exp_q.push_back(e);
        end
    endtask

    task automatic clear_stats();
        en_cnt = 0; first_en = -1; last_en = -1;
        done_cnt = 0; done_total = -1; done_err = 1'bx;
    endtask

    // Samples the current cycle at the falling edge and feeds the scoreboard.
    task automatic half();
        sb_t e;
        logic [7:0] act_b;
        @(negedge clk);
        cyc++;
        hs_seen = bif.word_valid && bif.word_ready;
        if (hs_seen) sb_push(bif.word_in, bif.word_last, bif.last_bytes);
        if (bif.count_enable) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            act_b = lane_byte(bif.data_save, bif.count_out);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got lane %0d byte %h, want no byte", bif.count_out, act_b);
            end else begin
                e = exp_q.pop_front();
                chk("sb_lane_byte", {21'h0, bif.count_out, act_b}, {21'h0, e.lane, e.b});
            end
        end
        if (bif.msg_done) begin
            done_cnt++;
            done_total = int'(bif.byte_total);
            done_err   = bif.ascii_err;
        end
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        fin();
    endtask

    task automatic push_word(input logic [31:0] w, input logic last, input logic [1:0] lb);
        logic ok;
        ok = 1'b0;
        bif.word_in    = w;
        bif.word_last  = last;
        bif.last_bytes = lb;
        bif.word_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            half();
            ok = hs_seen;
            fin();
        end
        bif.word_valid = 1'b0;
        chk("push_accepted", {31'h0, ok}, 32'h1);
    endtask

    task automatic drain(input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (done_cnt > 0 && !bif.busy) ok = 1'b1;
        end
        chk("drain_done", {31'h0, ok}, 32'h1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count_out"},  {29'h0, bif.count_out}, 32'h0);
        chk({tag, "_data_save"},  bif.data_save, 32'h0);
        chk({tag, "_msg_done"},   {31'h0, bif.msg_done}, 32'h0);
        chk({tag, "_byte_total"}, {16'h0, bif.byte_total}, 32'h0);
        chk({tag, "_ascii_err"},  {31'h0, bif.ascii_err}, 32'h0);
        chk({tag, "_word_ready"}, {31'h0, bif.word_ready}, 32'h1);
        chk({tag, "_busy"},       {31'h0, bif.busy}, 32'h0);
    endtask

    initial begin
        logic hit;
        vecs[0] = '{32'h44434241, 2'd0, 4, 1'b0};
        vecs[1] = '{32'h41804141, 2'd0, 3, 1'b1};
        vecs[2] = '{32'h00000041, 2'd1, 1, 1'b0};
        vecs[3] = '{32'h80414141, 2'd3, 3, 1'b0};
        vecs[4] = '{32'h41424344, 2'd2, 2, 1'b0};
        vecs[5] = '{32'h80808080, 2'd0, 0, 1'b1};
        vecs[6] = '{32'h11223344, 2'd0, 4, 1'b0};

        reset = 1'b0;
        bif.word_in = 32'h0; bif.word_valid = 1'b0; bif.word_last = 1'b0;
        bif.last_bytes = 2'd0; bif.stall = 1'b0;
        clear_stats();
        fin(); fin();
        half();
        chk_reset_state("rst");
        fin();
        reset = 1'b1;

        // Single word, cycle exact.
        clear_stats();
        push_word(32'h44434241, 1'b1, 2'd0);
        half(); chk("t1_count_out", {29'h0, bif.count_out}, 32'h0); fin();
        for (int k = 1; k <= 4; k++) begin
            half();
            chk("t_lane", {29'h0, bif.count_out}, 32'(k));
            chk("t_enable", {31'h0, bif.count_enable}, 32'h1);
            chk("t_data_save", bif.data_save, 32'h44434241);
            fin();
        end
        half();
        chk("t6_msg_done", {31'h0, bif.msg_done}, 32'h1);
        chk("t6_count_out", {29'h0, bif.count_out}, 32'h0);
        chk("t6_byte_total", {16'h0, bif.byte_total}, 32'd4);
        fin();
        half(); chk("t7_busy", {31'h0, bif.busy}, 32'h0); fin();

        // Three back-to-back words, third partial.
        clear_stats();
        push_word(32'h34333231, 1'b0, 2'd0);
        push_word(32'h38373635, 1'b0, 2'd0);
        push_word(32'h42414039, 1'b1, 2'd2);
        drain(60);
        chk("b2b_enables", 32'(en_cnt), 32'd10);
        chk("b2b_no_gap", 32'(last_en - first_en), 32'd9);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd1);
        chk("b2b_total", 32'(done_total), 32'd10);

        // Stall from the second byte for three cycles.
        clear_stats();
        push_word(32'h64636261, 1'b1, 2'd0);
        tick();
        half(); chk("st_lane1", {29'h0, bif.count_out}, 32'd1); fin();
        bif.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half();
            chk("st_hold_lane", {29'h0, bif.count_out}, 32'd2);
            chk("st_hold_enable", {31'h0, bif.count_enable}, 32'h0);
            fin();
        end
        bif.stall = 1'b0;
        half();
        chk("st_resume_lane", {29'h0, bif.count_out}, 32'd2);
        chk("st_resume_enable", {31'h0, bif.count_enable}, 32'h1);
        fin();
        drain(40);
        chk("st_enables", 32'(en_cnt), 32'd4);

        // Fill the FIFO under stall.
        clear_stats();
        bif.stall = 1'b1;
        for (int i = 0; i < 5; i++) push_word(32'h30313233 + 32'(i) * 32'h01010101, 1'b0, 2'd0);
        half(); chk("fill_ready_low", {31'h0, bif.word_ready}, 32'h0); fin();
        bif.word_in = 32'h35363738; bif.word_last = 1'b1; bif.last_bytes = 2'd0;
        bif.word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            half(); chk("fill_no_accept", {31'h0, hs_seen}, 32'h0); fin();
        end
        bif.stall = 1'b0;
        push_word(32'h35363738, 1'b1, 2'd0);
        drain(80);
        chk("fill_enables", 32'(en_cnt), 32'd24);
        chk("fill_total", 32'(done_total), 32'd24);
        chk("fill_done_cnt", 32'(done_cnt), 32'd1);

        // Table of single-word messages.
        foreach (vecs[i]) begin
            clear_stats();
            push_word(vecs[i].word, 1'b1, vecs[i].lb);
            drain(40);
            $display("vec %0d word %h lb %0d: total %0d err %b", i, vecs[i].word, vecs[i].lb, done_total, done_err);
            chk("vec_total", 32'(done_total), 32'(vecs[i].exp_total));
            chk("vec_ascii_err", {31'h0, done_err}, {31'h0, vecs[i].exp_err});
            chk("vec_done_cnt", 32'(done_cnt), 32'd1);
        end

        // Reset during lane 3 of a two-word message.
        clear_stats();
        push_word(32'h31323334, 1'b0, 2'd0);
        push_word(32'h35363738, 1'b1, 2'd0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            half();
            if (bif.count_out == 3'd3) hit = 1'b1;
            else fin();
        end
        chk("mid_reached_lane3", {31'h0, hit}, 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_state("mid_rst");
        exp_q.delete();
        fin();
        reset = 1'b1;
        clear_stats();
        for (int k = 0; k < 4; k++) tick();
        chk("mid_no_msg_done", 32'(done_cnt), 32'd0);
        chk("mid_idle_busy", {31'h0, bif.busy}, 32'h0);
        push_word(32'h45444342, 1'b1, 2'd0);
        tick();
        half(); chk("mid_fresh_lane1", {29'h0, bif.count_out}, 32'd1); fin();
        drain(40);
        chk("mid_fresh_total", 32'(done_total), 32'd4);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
